// File: rtl/cubic_feeder.sv
// Bicubic neighbour feeder: per request, reads four clamped source pixels along a row
// from a 1-cycle-latency ROM and streams them with phase/frac metadata to the cubic stage.
module cubic_feeder #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int AW    = 14
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  input  logic [6:0]    req_x,
  input  logic [6:0]    req_y,
  input  logic [7:0]    req_frac,
  output logic          req_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    P_out,
  output logic [2:0]    cycle_cnt,
  output logic          p_valid,
  output logic [7:0]    frac_out,
  output logic          win_last
);

  localparam int            WX    = AW + 1;
  localparam logic [WX-1:0] X_MAX = WX'(IMG_W - 1);
  localparam logic [AW-1:0] Y_MAX = AW'(IMG_H - 1);
  localparam logic [AW-1:0] W_A   = AW'(IMG_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [6:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    frac_q, frac_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          accept;

  // Address of neighbour k (0..3) of column x; out-of-range x is pulled to the last column first.
  function automatic logic [AW-1:0] nb_addr(input logic [6:0] x, input logic [6:0] y,
                                            input logic [1:0] k);
    logic [WX-1:0] xe, xs, xc;
    logic [AW-1:0] yc;
    xe = (WX'(x) > X_MAX) ? X_MAX : WX'(x);
    xs = xe + WX'(k);
    if (xs == '0)                  xc = '0;
    else if (xs - WX'(1) > X_MAX)  xc = X_MAX;
    else                           xc = xs - WX'(1);
    yc = (AW'(y) > Y_MAX) ? Y_MAX : AW'(y);
    return yc * W_A + xc[AW-1:0];
  endfunction

  assign req_ready = (state_q == IDLE) || (phase_q == 3'd4);
  assign accept    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    frac_d  = frac_q;
    addr_d  = '0;
    if (accept) begin
      state_d = RUN;
      phase_d = '0;
      x_d     = req_x;
      y_d     = req_y;
      frac_d  = req_frac;
      addr_d  = nb_addr(req_x, req_y, 2'd0);
    end else if (state_q == RUN) begin
      if (phase_q == 3'd4) begin
        state_d = IDLE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + 3'd1;
        if (phase_q != 3'd3) addr_d = nb_addr(x_q, y_q, phase_q[1:0] + 2'd1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frac_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frac_q  <= frac_d;
      addr_q  <= addr_d;
    end
  end

  // Read data trails the address by one cycle, so phases 1..4 carry P(-1)..P(2).
  assign p_valid   = (state_q == RUN) && (phase_q != 3'd0);
  assign P_out     = p_valid ? mem_rdata : '0;
  assign cycle_cnt = phase_q;
  assign win_last  = (state_q == RUN) && (phase_q == 3'd4);
  assign frac_out  = frac_q;
  assign mem_addr  = addr_q;

endmodule

// File: tb/tb_cubic_feeder.sv
// Randomized scoreboard bench for cubic_feeder: a request-level reference model pushes
// expected pixels on acceptance; a negedge monitor pops and compares as the DUT streams them.
module tb_cubic_feeder;

  localparam int W  = 100;
  localparam int H  = 100;
  localparam int AW = 14;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic [6:0]    req_x, req_y;
  logic [7:0]    req_frac;
  logic          req_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    P_out;
  logic [2:0]    cycle_cnt;
  logic          p_valid;
  logic [7:0]    frac_out;
  logic          win_last;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_wins = 0;

  cubic_feeder #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_frac(req_frac), .req_ready(req_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .P_out(P_out), .cycle_cnt(cycle_cnt), .p_valid(p_valid), .frac_out(frac_out),
    .win_last(win_last)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
    return a[7:0];
  endfunction

  always @(posedge CLK) mem_rdata <= rom_f(mem_addr);

  function automatic int ref_addr(input int x, input int y, input int k);
    int xe, xc, yc;
    xe = (x > W - 1) ? W - 1 : x;
    xc = xe + k - 1;
    if (xc < 0)     xc = 0;
    if (xc > W - 1) xc = W - 1;
    yc = (y > H - 1) ? H - 1 : y;
    return yc * W + xc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window position (-1 = idle) plus the latched request.
  int         m_phase = -1;
  int         m_x = 0, m_y = 0;
  logic [7:0] m_frac = 8'h00;
  logic       m_ready;
  logic [7:0] exp_q[$];

  assign m_ready = (m_phase < 0) || (m_phase == 4);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase <= -1;
      m_frac  <= 8'h00;
      exp_q.delete();
    end else if (req_valid && m_ready) begin
      m_phase <= 0;
      m_x     <= int'(req_x);
      m_y     <= int'(req_y);
      m_frac  <= req_frac;
      for (int k = 0; k < 4; k++)
        exp_q.push_back(rom_f(AW'(ref_addr(int'(req_x), int'(req_y), k))));
    end else if (m_phase == 4) begin
      m_phase <= -1;
    end else if (m_phase >= 0) begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("req_ready", req_ready, m_ready);
      check("cycle_cnt", cycle_cnt, (m_phase < 0) ? 0 : m_phase);
      check("p_valid", p_valid, m_phase >= 1);
      check("win_last", win_last, m_phase == 4);
      check("frac_out", frac_out, m_frac);
      if (m_phase >= 0 && m_phase <= 3)
        check("mem_addr", mem_addr, ref_addr(m_x, m_y, m_phase));
      if (p_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty actual=P_out %0d expected=no pixel", P_out);
        end else begin
          check("P_out", P_out, exp_q.pop_front());
        end
      end else begin
        check("P_out_idle", P_out, 0);
      end
      if (win_last) dut_wins++;
    end
  end

  task automatic issue(input int x, input int y, input logic [7:0] f);
    req_valid = 1'b1;
    req_x     = 7'(x);
    req_y     = 7'(y);
    req_frac  = f;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int w0;

  initial begin
    RST = 1'b1;
    req_valid = 1'b0;
    req_x = '0;
    req_y = '0;
    req_frac = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_P_out", P_out, 0);
    check("rst_p_valid", p_valid, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_frac_out", frac_out, 0);
    check("rst_win_last", win_last, 0);
    RST = 1'b0;

    // Directed windows, first one issued right after reset release.
    issue(10, 2, 8'h5A);  idle(6);
    issue(0, 0, 8'h11);   idle(6);
    issue(99, 0, 8'h22);  idle(6);
    issue(98, 5, 8'h33);  idle(6);
    issue(120, 7, 8'h44); idle(6);
    issue(50, 127, 8'h55); idle(6);

    // 17 back-to-back windows with request held valid.
    w0 = dut_wins;
    req_valid = 1'b1;
    repeat (81) begin
      req_x    = 7'($urandom_range(0, 127));
      req_y    = 7'($urandom_range(0, 127));
      req_frac = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    idle(6);
    check("b2b_windows", dut_wins - w0, 17);

    // Request at phase 2 must be ignored.
    w0 = dut_wins;
    issue(30, 40, 8'h66);
    idle(2);
    req_valid = 1'b1;
    req_x = 7'd5;
    req_y = 7'd6;
    req_frac = 8'h77;
    #1;
    check("ready_at_phase2", req_ready, 0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    idle(6);
    check("ignored_req_windows", dut_wins - w0, 1);

    // Asynchronous reset at phase 2.
    issue(20, 3, 8'h88);
    idle(2);
    RST = 1'b1;
    #1;
    check("arst_p_valid", p_valid, 0);
    check("arst_cycle_cnt", cycle_cnt, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_win_last", win_last, 0);
    check("arst_req_ready", req_ready, 1);
    idle(2);
    RST = 1'b0;
    issue(21, 4, 8'h99);
    idle(6);

    // Random traffic.
    repeat (500) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_x     = 7'($urandom_range(0, 127));
      req_y     = 7'($urandom_range(0, 127));
      req_frac  = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    idle(8);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
